// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
package fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 32;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its user.
interface param_fifo_if
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = ptr_width(DEPTH);

   logic             wr;
   logic [WIDTH-1:0] data_in;
   logic             rd;
   logic             err_clr;
   logic [WIDTH-1:0] data_out;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr, data_in, rd, err_clr,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr, data_in, rd, err_clr,
      output data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with cleared output.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_reg;

   // Array contents are never reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_reg <= '0;
      end else if (re) begin
         rdata_reg <= mem[raddr];
      end
   end

   assign rdata = rdata_reg;
endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointer, occupancy flag and sticky error logic around fifo_mem.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic        clk,
   input  logic        rst,
   param_fifo_if.slave bus
);
   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW-1:0] count;
   logic          full, empty;
   logic          wr_acc, rd_acc;
   logic          rd_valid_reg, overflow_reg, underflow_reg;

   // Modulo subtraction of wrap-bit pointers yields 0..DEPTH directly.
   assign count  = wr_ptr_reg - rd_ptr_reg;
   assign full   = (count == DEPTH_CNT);
   assign empty  = (count == '0);
   assign wr_acc = bus.wr & ~full;
   assign rd_acc = bus.rd & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         rd_valid_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         rd_valid_reg <= rd_acc;
         // A new error event wins over a coincident clear.
         if (bus.wr && full) begin
            overflow_reg <= 1'b1;
         end else if (bus.err_clr) begin
            overflow_reg <= 1'b0;
         end
         if (bus.rd && empty) begin
            underflow_reg <= 1'b1;
         end else if (bus.err_clr) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr_reg[AW-1:0]),
      .wdata (bus.data_in),
      .re    (rd_acc),
      .raddr (rd_ptr_reg[AW-1:0]),
      .rdata (bus.data_out)
   );

   assign bus.rd_valid     = rd_valid_reg;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AF_CNT);
   assign bus.almost_empty = (count <= AE_CNT);
   assign bus.count        = count;
   assign bus.overflow     = overflow_reg;
   assign bus.underflow    = underflow_reg;
endmodule
